// File: rtl/hangman_uart_pkg.sv
// Values shared by the letter-link transmitter and receiver, plus the
// control bytes the game logic exchanges over the radio link.
package hangman_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_state_t;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_CLKS_PER_BIT = 1042;

   // Non-letter control codes; letters travel as plain ASCII.
   localparam logic [7:0] WORD_END = 8'h0A;
   localparam logic [7:0] GAME_END = 8'h04;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// Receive side of the letter link: 8N1 deserializer with mid-bit sampling
// and a valid/ack holding register for the player FSM.
module uart_receiver
   import hangman_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DATA_BITS    = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 nRst,
   input  logic                 rx_serial,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_error,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_TC   = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   logic                 rx_sync;
   uart_state_t          state;
   logic [CW-1:0]        clk_cnt;
   logic [IW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift_reg;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (nRst),
      .d     (rx_serial),
      .q     (rx_sync)
   );

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state         <= IDLE;
         clk_cnt       <= '0;
         bit_idx       <= '0;
         shift_reg     <= '0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
         busy          <= 1'b0;
      end else begin
         framing_error <= 1'b0;
         overrun       <= 1'b0;
         // A load later in this block overrides the clear, so a coincident ack loses.
         if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rx_sync) begin
                  clk_cnt <= '0;
                  state   <= START;
                  busy    <= 1'b1;
               end
            end

            START: begin
               if (clk_cnt == HALF_TC) begin
                  clk_cnt <= '0;
                  if (!rx_sync) begin
                     bit_idx <= '0;
                     state   <= DATA;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            DATA: begin
               if (clk_cnt == BIT_TC) begin
                  clk_cnt   <= '0;
                  // LSB arrives first, so shifting in from the top lands it at bit 0.
                  shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                  bit_idx   <= bit_idx + 1'b1;
                  if (bit_idx == LAST_IDX) begin
                     state <= STOP;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            STOP: begin
               if (clk_cnt == BIT_TC) begin
                  clk_cnt <= '0;
                  if (rx_sync) begin
                     rx_data  <= shift_reg;
                     rx_valid <= 1'b1;
                     overrun  <= rx_valid && !rx_ack;
                     state    <= IDLE;
                     busy     <= 1'b0;
                  end else begin
                     framing_error <= 1'b1;
                     state         <= WAIT_HIGH;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            WAIT_HIGH: begin
               if (rx_sync) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive side of the wireless letter link: deserializes 8N1 UART frames from the radio module's RX pin into bytes (ASCII letters, control codes) for the player-side game logic.
- Counterpart to the host-side transmitter that raises msg_sent; sits between the radio RX pad and the player FSM.
- Oversamples with a bit-period counter, samples mid-bit, checks the stop bit, holds each byte under a valid/ack handshake.

Parameters:
- CLKS_PER_BIT, 1042, clk cycles per UART bit (10 MHz / 9600 baud); must be >= 4. Benches use 16.
- DATA_BITS, 8, payload bits per frame, LSB first.

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- rx_serial  in  1  raw asynchronous serial line, idle high
- rx_ack  in  1  consumer accepts current byte; single-cycle pulse
- rx_data  out  DATA_BITS  last good byte received
- rx_valid  out  1  byte available; held until acknowledged
- framing_error  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: new byte overwrote an unacknowledged byte
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, nRst=0): synchronizer flops = 1; state = IDLE; counters = 0; rx_data = 0; rx_valid = 0; framing_error = 0; overrun = 0; busy = 0. Reset mid-frame abandons the frame, and no partial byte becomes visible.
- Input path: 2-flop synchronizer on rx_serial gives rx_sync, so 2 cycles latency. All decisions use rx_sync only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rx_sync = 0, clear bit counter and go to START.
- START: count to CLKS_PER_BIT/2 - 1 (integer divide). At the terminal count:
  - if rx_sync = 0: clear counter, bit index = 0, go to DATA;
  - else the low was a glitch: return to IDLE with no flag raised.
- DATA: count to CLKS_PER_BIT-1. At the terminal count, shift rx_sync into shift_reg[bit_idx] (LSB first), clear counter, increment bit_idx. After bit DATA_BITS-1 is sampled, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample:
  - rx_sync = 1: on the next edge, rx_data <= shift_reg and rx_valid <= 1. If rx_valid was already 1 and rx_ack is low that cycle, pulse overrun and overwrite rx_data. Go to IDLE.
  - rx_sync = 0: pulse framing_error, discard the byte, leave rx_data and rx_valid unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_sync = 1, then go to IDLE. A held-low (break) line raises exactly one framing_error.
- Returning to IDLE at mid-stop-bit means back-to-back frames with zero idle gap are received.
- Handshake rules:
  - rx_ack while rx_valid = 1 clears rx_valid next cycle.
  - rx_ack while rx_valid = 0 is ignored.
  - rx_ack in the same cycle a new byte loads: new byte wins, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles (±1) after the start-bit falling edge on rx_serial.
- Width rules:
  - bit counter width = $clog2(CLKS_PER_BIT); it never exceeds CLKS_PER_BIT-1 and wraps to 0 at terminal count.
  - bit_idx width = $clog2(DATA_BITS+1).
- busy = (state != IDLE), registered from state.

Decomposition:
- Shared package hangman_uart_pkg holds:
  - uart_state_t enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - UART_DATA_BITS = 8 and UART_CLKS_PER_BIT = 1042, so the transmitter uses the same values;
  - letter/control byte constants used by the game (e.g. WORD_END, GAME_END).
- One sub-module: sync2, a two-flop synchronizer with reset value parameter RST_VAL = 1.

Test Plan (CLKS_PER_BIT=16):
- Drive frame for 0x41 ('A'), no ack -> rx_valid rises about 155 cycles after the start edge; rx_data = 0x41; framing_error and overrun stay 0; busy high during the frame.
- Drive a 3-cycle low glitch on an idle line -> FSM returns to IDLE; rx_valid, framing_error and busy return low within 12 cycles; rx_data unchanged.
- Frame 0x50 with stop bit forced 0, then line high -> exactly one framing_error pulse; rx_valid stays 0; next frame 0x45 is received correctly.
- Back-to-back frames 0x4D then 0x52 with no ack and no idle gap -> one overrun pulse at the second load; rx_data = 0x52; then ack -> rx_valid = 0 next cycle.
- Ack coincident with the load of 0x48 while 0x54 is pending -> rx_valid stays 1, rx_data = 0x48, no overrun.
- Assert nRst during bit 4 of a frame -> all outputs reset immediately; after release, frame 0x49 is received with rx_data = 0x49 and no errors.
